mem_port_arbiter: RTL and testbench

- Shares the single SRAM-like memory port between two requesters: instruction fetch (IF stage) and load/store (MEM stage).
- Sequences one outstanding transaction at a time with a req / addr_ok / data_ok handshake on both the requester side and the bus side.
- The pipeline stalls on the missing data_ok, so this block is the only place fetch-vs-data contention is resolved.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_arb_prio.sv | 36 +++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Wide enough for MAX_DATA_STREAK up to 15.
  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and load/store, with a streak limit so a
// continuous stream of data requests cannot starve instruction fetch.
module mem_arb_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inst_req,
  input  logic data_req,
  input  logic grant_en,
  output logic grant_data
);

  logic [STREAK_W-1:0] streak;
  logic                at_limit;

  assign at_limit   = (streak == STREAK_W'(MAX_DATA_STREAK));
  assign grant_data = data_req && !(inst_req && at_limit);

  // The streak only counts data grants that made a waiting fetch wait longer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (grant_en && (inst_req || data_req)) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (!grant_data || !inst_req) begin
        streak <= '0;
      end else if (!at_limit) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like req/addr_ok/data_ok memory port between instruction
// fetch and load/store, one outstanding transaction at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              arb_busy
);

  state_e state_q;
  owner_e owner_q;
  logic   grant_data;
  logic   addr_phase_ok;
  logic   data_phase_ok;

  mem_arb_prio #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_prio (
    .clk       (clk),
    .reset     (reset),
    .inst_req  (inst_req),
    .data_req  (data_req),
    .grant_en  (state_q == IDLE),
    .grant_data(grant_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_DATA;
      // NOTE: the latched bus fields are reset as well, so every output reads 0 in reset.
      bus_wr    <= 1'b0;
      bus_size  <= '0;
      bus_wstrb <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (inst_req || data_req) begin
            state_q <= ADDR;
            if (grant_data) begin
              owner_q   <= OWN_DATA;
              bus_wr    <= data_wr;
              bus_size  <= data_size;
              bus_wstrb <= data_wstrb;
              bus_addr  <= data_addr;
              bus_wdata <= data_wdata;
            end else begin
              owner_q   <= OWN_INST;
              bus_wr    <= 1'b0;
              bus_size  <= SZ_WORD;
              bus_wstrb <= '0;
              bus_addr  <= inst_addr;
              bus_wdata <= '0;
            end
          end
        end
        // A data_ok coincident with addr_ok is dropped: DATA is checked only from the next cycle.
        ADDR: if (bus_addr_ok) state_q <= DATA;
        DATA: if (bus_data_ok) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_req  = (state_q == ADDR);
  assign arb_busy = (state_q != IDLE);

  // Requester strobes pass the slave handshake straight through to the owner.
  assign addr_phase_ok = (state_q == ADDR) && bus_addr_ok;
  assign data_phase_ok = (state_q == DATA) && bus_data_ok;

  assign inst_addr_ok = addr_phase_ok && (owner_q == OWN_INST);
  assign data_addr_ok = addr_phase_ok && (owner_q == OWN_DATA);
  assign inst_data_ok = data_phase_ok && (owner_q == OWN_INST);
  assign data_data_ok = data_phase_ok && (owner_q == OWN_DATA);

  assign inst_rdata = inst_data_ok ? bus_rdata : '0;
  assign data_rdata = data_data_ok ? bus_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model is compared
// against the DUT every cycle, plus hand-computed timing/order expectations.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAX = 4;

  typedef struct packed {
    logic          wr;
    logic [1:0]    size;
    logic [3:0]    wstrb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dreq_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          inst_req, data_req, data_wr;
  logic [AW-1:0] inst_addr, data_addr;
  logic [1:0]    data_size;
  logic [3:0]    data_wstrb;
  logic [DW-1:0] data_wdata;
  logic          bus_addr_ok, bus_data_ok;
  logic [DW-1:0] bus_rdata;

  logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DW-1:0] inst_rdata, data_rdata;
  logic          bus_req, bus_wr, arb_busy;
  logic [1:0]    bus_size;
  logic [3:0]    bus_wstrb;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .arb_busy(arb_busy)
  );

  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_log(input string name, input string act, input string exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
  endtask

  // Requesters, slave and manual bus overrides
  logic [AW-1:0] iq[$];
  dreq_t         dq[$];
  logic          inst_acc = 1'b0, data_acc = 1'b0;
  logic          slave_en = 1'b1;
  logic          man_aok = 1'b0, man_dok = 1'b0;
  int            addr_wait = 0, data_wait = 0;
  logic [DW-1:0] rdata_val = '0;
  logic          sl_phase = 1'b0;
  int            sl_cnt = 0;
  logic          s_aok = 1'b0, s_dok = 1'b0;

  // Transaction-level model
  logic          m_active = 1'b0, m_aok = 1'b0, m_data = 1'b1;
  int            m_run = 0;
  logic          m_wr = 1'b0;
  logic [1:0]    m_size = '0;
  logic [3:0]    m_wstrb = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;

  // Observations for the literal expectations
  string         obs_log, mdl_log;
  int            t_iaok, t_idok, t_daok, t_ddok;
  int            n_iaok, n_idok, n_daok, n_ddok;
  logic          wr_at_daok;
  logic [DW-1:0] irdata_seen, drdata_seen;

  task automatic clear_obs();
    obs_log = ""; mdl_log = "";
    t_iaok = -1; t_idok = -1; t_daok = -1; t_ddok = -1;
    n_iaok = 0; n_idok = 0; n_daok = 0; n_ddok = 0;
    wr_at_daok = 1'b0; irdata_seen = '0; drdata_seen = '0;
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_aok = 1'b0; m_data = 1'b1; m_run = 0;
    m_wr = 1'b0; m_size = '0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
  endtask

  // One transaction at a time; data first unless fetch has waited MAX data grants.
  task automatic model_step();
    if (!reset) begin
      model_reset();
    end else if (!m_active) begin
      if (inst_req || data_req) begin
        m_data = data_req && !(inst_req && m_run == MAX);
        if (m_data) begin
          m_run   = inst_req ? ((m_run < MAX) ? m_run + 1 : MAX) : 0;
          m_wr    = data_wr;   m_size = data_size; m_wstrb = data_wstrb;
          m_addr  = data_addr; m_wdata = data_wdata;
          mdl_log = {mdl_log, "D"};
        end else begin
          m_run   = 0;
          m_wr    = 1'b0; m_size = 2'd2; m_wstrb = 4'h0;
          m_addr  = inst_addr;
          mdl_log = {mdl_log, "I"};
        end
        m_active = 1'b1;
        m_aok    = 1'b0;
      end
    end else if (!m_aok) begin
      if (bus_addr_ok) m_aok = 1'b1;
    end else if (bus_data_ok) begin
      m_active = 1'b0;
    end
  endtask

  task automatic drive();
    if (!reset) begin
      sl_phase = 1'b0; sl_cnt = 0; s_aok = 1'b0; s_dok = 1'b0;
    end else if (!sl_phase) begin
      s_dok = 1'b0;
      if (bus_req && sl_cnt == addr_wait) begin
        s_aok = 1'b1; sl_phase = 1'b1; sl_cnt = 0;
      end else begin
        s_aok = 1'b0; sl_cnt = bus_req ? sl_cnt + 1 : 0;
      end
    end else begin
      s_aok = 1'b0;
      if (sl_cnt == data_wait) begin
        s_dok = 1'b1; sl_phase = 1'b0; sl_cnt = 0;
      end else begin
        s_dok = 1'b0; sl_cnt++;
      end
    end
    bus_addr_ok = slave_en ? s_aok : man_aok;
    bus_data_ok = slave_en ? s_dok : man_dok;
    bus_rdata   = rdata_val;

    if (inst_acc && iq.size() > 0) void'(iq.pop_front());
    if (data_acc && dq.size() > 0) void'(dq.pop_front());
    inst_req  = (iq.size() > 0);
    inst_addr = inst_req ? iq[0] : '0;
    data_req  = (dq.size() > 0);
    if (data_req) begin
      data_wr = dq[0].wr; data_size = dq[0].size; data_wstrb = dq[0].wstrb;
      data_addr = dq[0].addr; data_wdata = dq[0].wdata;
    end else begin
      data_wr = 1'b0; data_size = '0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    end
  endtask

  task automatic compare();
    logic e_breq, e_iaok, e_daok, e_idok, e_ddok;
    e_breq = m_active && !m_aok;
    e_iaok = e_breq && !m_data && bus_addr_ok;
    e_daok = e_breq &&  m_data && bus_addr_ok;
    e_idok = m_active && m_aok && !m_data && bus_data_ok;
    e_ddok = m_active && m_aok &&  m_data && bus_data_ok;
    check("arb_busy", arb_busy, m_active);
    check("bus_req", bus_req, e_breq);
    check("inst_addr_ok", inst_addr_ok, e_iaok);
    check("data_addr_ok", data_addr_ok, e_daok);
    check("inst_data_ok", inst_data_ok, e_idok);
    check("data_data_ok", data_data_ok, e_ddok);
    check("inst_rdata", inst_rdata, e_idok ? bus_rdata : '0);
    check("data_rdata", data_rdata, e_ddok ? bus_rdata : '0);
    if (e_breq) begin
      check("bus_wr", bus_wr, m_wr);
      check("bus_size", bus_size, m_size);
      check("bus_wstrb", bus_wstrb, m_wstrb);
      check("bus_addr", bus_addr, m_addr);
      if (m_data) check("bus_wdata", bus_wdata, m_wdata);
    end
    inst_acc = inst_addr_ok;
    data_acc = data_addr_ok;
    if (inst_addr_ok) begin obs_log = {obs_log, "I"}; t_iaok = cyc; n_iaok++; end
    if (data_addr_ok) begin obs_log = {obs_log, "D"}; t_daok = cyc; n_daok++; wr_at_daok = bus_wr; end
    if (inst_data_ok) begin t_idok = cyc; n_idok++; irdata_seen = inst_rdata; end
    if (data_data_ok) begin t_ddok = cyc; n_ddok++; drdata_seen = data_rdata; end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    drive();
    cyc++;
    @(negedge clk);
    compare();
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int   n;
    logic done;
    n = 0;
    do begin
      cycle();
      n++;
      done = !(iq.size() > 0 || dq.size() > 0 || inst_req || data_req || m_active || arb_busy);
    end while (!done && n < budget);
    check({name, " completes within budget"}, done, 1'b1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " strobes"}, {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                              bus_req, arb_busy, bus_wr}, '0);
    check({name, " rdata"}, {inst_rdata, data_rdata}, '0);
    check({name, " bus fields"}, {bus_size, bus_wstrb, bus_addr}, '0);
    check({name, " bus_wdata"}, bus_wdata, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   t0;
    int   n;
    logic in_data;
    inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
    data_size = '0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    clear_obs();

    // Power-on reset
    #1 reset = 1'b0;
    #1 check_all_zero("power-on reset");
    repeat (2) cycle();
    #2 reset = 1'b1;

    // Lone fetch
    clear_obs();
    rdata_val = 32'h3C080001;
    t0 = cyc + 1;
    iq.push_back(32'hBFC00000);
    run_until_idle("lone fetch", 20);
    check("lone fetch inst_addr_ok cycle", t_iaok - t0, 1);
    check("lone fetch inst_data_ok cycle", t_idok - t0, 2);
    check("lone fetch inst_rdata", irdata_seen, 32'h3C080001);
    check("lone fetch data strobes", n_daok + n_ddok, 0);

    // Contention: store wins, fetch follows after one IDLE cycle
    clear_obs();
    rdata_val = 32'h0000_0000;
    dq.push_back('{wr: 1'b1, size: 2'd2, wstrb: 4'hF, addr: 32'h80000010, wdata: 32'hDEADBEEF});
    iq.push_back(32'hBFC00004);
    run_until_idle("contention", 30);
    check_log("contention grant order", obs_log, "DI");
    check("contention bus_wr at data grant", wr_at_daok, 1'b1);
    check("contention fetch addr_ok after data_ok", t_iaok - t_ddok, 2);

    // Starvation guard: fetch gets in after MAX consecutive data grants
    clear_obs();
    rdata_val = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++)
      dq.push_back('{wr: 1'b0, size: 2'd2, wstrb: 4'h0, addr: 32'h1000 + 32'(4 * i), wdata: '0});
    iq.push_back(32'hBFC00008);
    run_until_idle("starvation", 60);
    check_log("starvation grant order (DUT)", obs_log, "DDDDID");
    check_log("starvation grant order (model)", mdl_log, "DDDDID");

    // Wait states on both bus phases
    clear_obs();
    addr_wait = 3; data_wait = 2;
    rdata_val = 32'h1234_5678;
    t0 = cyc + 1;
    dq.push_back('{wr: 1'b0, size: 2'd1, wstrb: 4'h0, addr: 32'h80000022, wdata: '0});
    run_until_idle("wait states", 30);
    check("wait states data_addr_ok cycle", t_daok - t0, 4);
    check("wait states data_data_ok cycle", t_ddok - t0, 7);
    check("wait states strobe counts", {n_daok[15:0], n_ddok[15:0]}, {16'd1, 16'd1});
    check("wait states data_rdata", drdata_seen, 32'h1234_5678);
    addr_wait = 0; data_wait = 0;

    // Stray bus_data_ok / bus_addr_ok under manual control
    clear_obs();
    slave_en = 1'b0;
    rdata_val = 32'h0BAD_F00D;
    man_aok = 1'b1; man_dok = 1'b1; cycle();
    man_aok = 1'b0; man_dok = 1'b0;
    t0 = cyc + 1;
    dq.push_back('{wr: 1'b0, size: 2'd0, wstrb: 4'h0, addr: 32'h00002000, wdata: '0});
    cycle();
    man_aok = 1'b1; man_dok = 1'b1; cycle();
    man_aok = 1'b1; man_dok = 1'b0; cycle();
    man_aok = 1'b0; man_dok = 1'b1; cycle();
    man_aok = 1'b0; man_dok = 1'b1; cycle();
    man_aok = 1'b0; man_dok = 1'b0; cycle();
    slave_en = 1'b1;
    check("stray data_addr_ok cycle", t_daok - t0, 1);
    check("stray data_data_ok cycle", t_ddok - t0, 3);
    check("stray strobe counts", {n_daok[15:0], n_ddok[15:0], n_iaok[15:0], n_idok[15:0]},
          {16'd1, 16'd1, 16'd0, 16'd0});
    check("stray ends idle", arb_busy, 1'b0);

    // Reset asserted while a fetch sits in the data phase
    clear_obs();
    data_wait = 5;
    rdata_val = 32'hCAFE_F00D;
    iq.push_back(32'hBFC00100);
    n = 0;
    do begin
      cycle();
      n++;
      in_data = m_active && m_aok;
    end while (!in_data && n < 10);
    cycle();
    check("reset test reached data phase", arb_busy && !bus_req, 1'b1);
    #2 reset = 1'b0;
    #1 check_all_zero("reset mid-DATA");
    model_reset();
    clear_obs();
    data_wait = 0;
    iq.push_back(32'hBFC00200);
    repeat (2) cycle();
    #2 reset = 1'b1;
    t0 = cyc;
    run_until_idle("after reset", 20);
    check("after reset inst_data_ok count", n_idok, 1);
    check("after reset inst_data_ok cycle", t_idok - t0, 2);
    check("after reset inst_rdata", irdata_seen, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
